mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4096 locations).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Clocking: the block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  copy request, sampled only in IDLE.
REQ-007 src_addr  input  ADDR_W  first source address.
REQ-008 dst_addr  input  ADDR_W  first destination address.
REQ-009 length  input  ADDR_W+1  byte count, 0..4096.
REQ-010 busy  output  1  high in RD and WR states.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 mem_addr  output  ADDR_W  drives memory Address.
REQ-013 mem_din  output  DATA_W  drives memory Din.
REQ-014 mem_read  output  1  drives memory Read.
REQ-015 mem_write  output  1  drives memory Write.
REQ-016 mem_dout  input  DATA_W  memory Dout; combinational, valid while mem_read=1.
REQ-017 checksum  output  DATA_W  present only with MEM_COPY_CHECKSUM_EN.

Function
REQ-018 The block SHALL implement the FSM states IDLE, RD, WR and DONE, encoded in a single state register.
REQ-019 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-020 In IDLE with start=1 and length!=0, the block SHALL latch src_addr, dst_addr and length, and enter RD on the next edge.
REQ-021 In IDLE with start=1 and length=0, the block SHALL go directly to DONE without any memory access.
REQ-022 In RD, the block SHALL drive mem_read=1, mem_write=0 and mem_addr=src+idx; at the closing edge it SHALL capture mem_dout into the data register and enter WR.
REQ-023 In WR, the block SHALL drive mem_read=0, mem_write=1, mem_addr=dst+idx and mem_din=captured data; at the closing edge it SHALL increment idx.
REQ-024 On leaving WR, the block SHALL enter RD if idx+1<length, otherwise DONE.
REQ-025 The block SHALL never assert mem_read and mem_write in the same cycle.
REQ-026 mem_addr and mem_din SHALL be stable for the entire cycle in which mem_write=1.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W, so src+idx and dst+idx wrap from 4095 to 0.
REQ-028 The block SHALL copy in forward order only and SHALL NOT correct for overlapping source and destination ranges.
REQ-029 Latency: with start sampled at edge N, the first RD cycle SHALL be N+1 and DONE SHALL be cycle N+1+2*length; total cost is 2 cycles per byte plus 1.
REQ-030 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-031 start SHALL be ignored in RD, WR and DONE; a start held high SHALL launch a new copy on the first IDLE cycle after DONE.
REQ-032 In IDLE and DONE, mem_read and mem_write SHALL both be 0.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-copy.
REQ-034 Reset values SHALL be: busy=0, done=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0, idx=0 and checksum=0.
REQ-035 Memory contents already written before a reset SHALL NOT be rolled back; an aborted copy leaves a partial destination range.

Configuration
REQ-036 With MEM_COPY_CHECKSUM_EN defined, the checksum port SHALL exist, SHALL clear to 0 on accepting start, and SHALL add each captured byte modulo 2^DATA_W at the RD edge; it SHALL hold its value after DONE until the next start.
REQ-037 Without MEM_COPY_CHECKSUM_EN, the checksum port and its accumulator SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Memory holds [0]=5, [1]=7, [2]=9; start with src=0, dst=100, len=3 -> [100..102]=5,7,9, done at start edge+7, checksum=21.
REQ-039 Start with len=0 -> done on the next cycle; mem_read and mem_write stay 0 throughout.
REQ-040 Start with src=4094, dst=10, len=4 -> reads from 4094, 4095, 0, 1, and bytes land at 10..13.
REQ-041 Assert rst during the second WR of a len=5 copy -> IDLE next cycle, all outputs 0, only dst+0 and dst+1 written.
REQ-042 Pulse start again while busy -> ignored; hold start through DONE -> a second copy begins on the cycle after the IDLE cycle.
REQ-043 Throughout all tests, assert mem_read&mem_write==0 and that mem_addr does not change while mem_write=1.

Source files
------------

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Byte-serial memory-to-memory copy engine driving a single
//                port memory with a combinational read path. Each byte costs
//                one read cycle (RD) and one write cycle (WR); a copy ends
//                with a one-cycle DONE pulse. Forward order only, addresses
//                wrap modulo 2^ADDR_W, overlapping ranges are not corrected.
//  Optional    : define MEM_COPY_CHECKSUM_EN to add the checksum port, a
//                modulo-2^DATA_W sum of every byte read by the last copy.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - copy request (only looked at in IDLE)
//                src_addr        - first source address
//                dst_addr        - first destination address
//                length          - byte count, 0 .. 2^ADDR_W
//                busy            - high while reading/writing
//                done            - one-cycle completion pulse
//                mem_addr/din    - memory address and write data
//                mem_read/write  - memory strobes (never both high)
//                mem_dout        - memory read data, valid while mem_read=1
//                checksum        - byte sum (MEM_COPY_CHECKSUM_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_idx_one = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    // Index of the byte following the one being written. It is one bit wider
    // than an address so a full 2^ADDR_W copy terminates correctly.
    logic [ADDR_W:0] w_idx_nxt;
    logic            w_more;

    assign w_idx_nxt = r_idx + c_idx_one;
    assign w_more    = (w_idx_nxt < r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_len <= length;
                        r_idx <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
                        r_sum <= '0;
`endif
                        if (length != '0) begin
                            // Present the first read already in the first RD cycle.
                            r_state <= ST_RD;
                            r_busy  <= 1'b1;
                            r_read  <= 1'b1;
                            r_addr  <= src_addr;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    // Memory read data is combinational: capture it at the
                    // closing edge and turn the port around for the write.
                    r_data  <= mem_dout;
                    r_read  <= 1'b0;
                    r_write <= 1'b1;
                    r_addr  <= r_dst + r_idx[ADDR_W-1:0];
`ifdef MEM_COPY_CHECKSUM_EN
                    r_sum   <= r_sum + mem_dout;
`endif
                    r_state <= ST_WR;
                end

                ST_WR: begin
                    r_write <= 1'b0;
                    r_idx   <= w_idx_nxt;
                    if (w_more) begin
                        r_state <= ST_RD;
                        r_read  <= 1'b1;
                        r_addr  <= r_src + w_idx_nxt[ADDR_W-1:0];
                    end else begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_addr  = r_addr;
    assign mem_din   = r_data;
    assign mem_read  = r_read;
    assign mem_write = r_write;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum  = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Self-checking bench for mem_copy_engine. A byte-array copy
//                model predicts the memory image, the read/write timeline
//                and the checksum of each copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    localparam int c_addr_w = 12;
    localparam int c_data_w = 8;
    localparam int c_depth  = 1 << c_addr_w;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [c_addr_w-1:0] src_addr;
    logic [c_addr_w-1:0] dst_addr;
    logic [c_addr_w:0]   length;
    logic                busy;
    logic                done;
    logic [c_addr_w-1:0] mem_addr;
    logic [c_data_w-1:0] mem_din;
    logic                mem_read;
    logic                mem_write;
    logic [c_data_w-1:0] mem_dout;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [c_data_w-1:0] checksum;
`endif

    logic [c_data_w-1:0] mem     [c_depth];
    logic [c_data_w-1:0] ref_mem [c_depth];
    logic                preload;

    int n_cmp = 0;
    int n_err = 0;

    logic [c_addr_w-1:0] a_early;
    logic [c_data_w-1:0] d_early;

    mem_copy_engine #(
        .ADDR_W(c_addr_w),
        .DATA_W(c_data_w)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_read (mem_read),
        .mem_write(mem_write),
`ifdef MEM_COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write at the clock edge; preload copies the
    // whole reference image in one cycle.
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_din;
        end else if (preload) begin
            for (int i = 0; i < c_depth; i++) mem[i] <= ref_mem[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; protocol checks ride along on every cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        a_early = mem_addr;
        d_early = mem_din;
        @(negedge clk);
        check_val("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (mem_write) begin
            check_val("wr_addr_stable", 32'(mem_addr), 32'(a_early));
            check_val("wr_data_stable", 32'(mem_din), 32'(d_early));
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < c_depth; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check_val(tag, 32'(diffs), 32'd0);
    endtask

    // One full copy with its expected timeline; pulse_j>0 pulses start (with
    // different parameters) in that cycle of the copy.
    task automatic run_copy(input int s, input int d, input int len, input int pulse_j);
        int sum;
        int rd_b[$];
        int exp_busy, exp_done, exp_rd, exp_wr, k;
        sum = 0;
        for (int i = 0; i < len; i++) begin
            int b;
            b = int'(ref_mem[(s + i) % c_depth]);
            rd_b.push_back(b);
            ref_mem[(d + i) % c_depth] = 8'(b);
            sum += b;
        end
        src_addr = 12'(s);
        dst_addr = 12'(d);
        length   = 13'(len);
        start    = 1'b1;
        for (int j = 1; j <= 2 * len + 2; j++) begin
            cyc();
            exp_busy = (j <= 2 * len) ? 1 : 0;
            exp_done = (j == 2 * len + 1) ? 1 : 0;
            exp_rd   = (j <= 2 * len && j % 2 == 1) ? 1 : 0;
            exp_wr   = (j <= 2 * len && j % 2 == 0) ? 1 : 0;
            k        = (j - 1) / 2;
            check_val("busy", 32'(busy), 32'(exp_busy));
            check_val("done", 32'(done), 32'(exp_done));
            check_val("mem_read", 32'(mem_read), 32'(exp_rd));
            check_val("mem_write", 32'(mem_write), 32'(exp_wr));
            if (exp_rd == 1) check_val("rd_addr", 32'(mem_addr), 32'((s + k) % c_depth));
            if (exp_wr == 1) begin
                check_val("wr_addr", 32'(mem_addr), 32'((d + k) % c_depth));
                check_val("wr_data", 32'(mem_din), 32'(rd_b[k]));
            end
`ifdef MEM_COPY_CHECKSUM_EN
            if (j == 2 * len + 2) check_val("checksum", 32'(checksum), 32'(sum % 256));
`endif
            if (j == 1 || (pulse_j > 0 && j == pulse_j + 1)) start = 1'b0;
            if (j == pulse_j) begin
                start    = 1'b1;
                src_addr = ~src_addr;
                dst_addr = ~dst_addr;
                length   = 13'd1;
            end
        end
        for (int i = 0; i < len; i++)
            check_val("dst_byte", 32'(mem[(d + i) % c_depth]), 32'(ref_mem[(d + i) % c_depth]));
        check_mem("mem_image");
    endtask

    // Reset asserted during the second WR of a 5-byte copy.
    task automatic run_abort();
        int s, d;
        s = 200;
        d = 300;
        for (int i = 0; i < 2; i++) ref_mem[d + i] = ref_mem[s + i];
        src_addr = 12'(s);
        dst_addr = 12'(d);
        length   = 13'd5;
        start    = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            if (j == 1) start = 1'b0;
        end
        check_val("abort_in_wr2", 32'(mem_write), 32'd1);
        rst = 1'b1;
        cyc();
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_read", 32'(mem_read), 32'd0);
        check_val("abort_write", 32'(mem_write), 32'd0);
        check_val("abort_addr", 32'(mem_addr), 32'd0);
        check_val("abort_din", 32'(mem_din), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check_val("abort_checksum", 32'(checksum), 32'd0);
`endif
        rst = 1'b0;
        cyc();
        check_val("abort_stays_idle", 32'(busy | mem_read | mem_write), 32'd0);
        check_mem("abort_image");
    endtask

    // start held high through DONE: second copy's first RD follows one IDLE cycle.
    task automatic run_hold();
        int exp_busy, exp_done, exp_rd;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 2; i++) ref_mem[60 + i] = ref_mem[50 + i];
        src_addr = 12'd50;
        dst_addr = 12'd60;
        length   = 13'd2;
        start    = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            exp_busy = ((j >= 1 && j <= 4) || (j >= 7 && j <= 10)) ? 1 : 0;
            exp_done = (j == 5 || j == 11) ? 1 : 0;
            exp_rd   = (j == 1 || j == 3 || j == 7 || j == 9) ? 1 : 0;
            check_val("hold_busy", 32'(busy), 32'(exp_busy));
            check_val("hold_done", 32'(done), 32'(exp_done));
            check_val("hold_read", 32'(mem_read), 32'(exp_rd));
            if (j == 7) begin
                check_val("hold_restart_addr", 32'(mem_addr), 32'd50);
                start = 1'b0;
            end
        end
        check_mem("hold_image");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        preload  = 1'b0;
        for (int i = 0; i < c_depth; i++) ref_mem[i] = 8'($urandom);
        preload = 1'b1;
        cyc();
        preload = 1'b0;
        cyc();
        cyc();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_read", 32'(mem_read), 32'd0);
        check_val("rst_write", 32'(mem_write), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_din", 32'(mem_din), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check_val("rst_checksum", 32'(checksum), 32'd0);
`endif
        rst = 1'b0;
        cyc();

        ref_mem[0] = 8'd5;
        ref_mem[1] = 8'd7;
        ref_mem[2] = 8'd9;
        preload = 1'b1;
        cyc();
        preload = 1'b0;

        run_copy(0, 100, 3, 0);        // basic 3-byte copy, checksum 21
        run_copy(5, 6, 0, 0);          // zero length: immediate DONE
        run_copy(4094, 10, 4, 0);      // source wraps 4095 -> 0
        run_copy(4093, 4094, 5, 0);    // destination wraps, forward overlap
        run_copy(300, 400, 6, 3);      // start pulsed while busy
        run_copy(500, 502, 8, 0);      // overlapping forward copy
        run_abort();
        run_hold();

        for (int it = 0; it < 12; it++) begin
            int s, d, len, p;
            s   = int'($urandom_range(0, c_depth - 1));
            d   = int'($urandom_range(0, c_depth - 1));
            len = int'($urandom_range(0, 20));
            p   = 0;
            if (len >= 2 && $urandom_range(0, 1) == 1) p = int'($urandom_range(2, 2 * len - 1));
            run_copy(s, d, len, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
